// File: rtl/tty_kl8e.sv
// KL8E-style console teletype: keyboard (03) / printer (04) IOTs and uart req/ack host.
// Define TTY_INT_EN to add the interrupt enable (KIE) and a live io_irq.
module tty_kl8e (
    input  logic        clk,
    input  logic        reset,
    input  logic        iot,
    input  logic [5:0]  io_dev,
    input  logic [2:0]  io_op,
    input  logic [11:0] io_data_in,
    output logic        io_done,
    output logic [11:0] io_data_out,
    output logic        io_clear_ac,
    output logic        io_skip,
    output logic        io_irq,
    output logic        tx_req,
    input  logic        tx_ack,
    output logic [7:0]  tx_data,
    input  logic        tx_empty,
    output logic        rx_req,
    input  logic        rx_ack,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty
);

    localparam logic [5:0] KBD_DEV = 6'o03;
    localparam logic [5:0] TTO_DEV = 6'o04;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_REQ   = 2'd1;
    localparam logic [1:0] R_REL   = 2'd2;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_REQ   = 2'd1;
    localparam logic [1:0] T_REL   = 2'd2;
    localparam logic [1:0] T_DRAIN = 2'd3;

    logic [1:0] tx_ack_q, tx_empty_q, rx_ack_q, rx_empty_q;
    logic       tx_ack_s, tx_empty_s, rx_ack_s, rx_empty_s;

    logic [1:0] rx_state, tx_state;
    logic [7:0] kbd_buf, tto_buf;
    logic       kbd_flag, tto_flag, tx_pend;

    logic kbd_hit, tto_hit;
    logic kbd_clr, tto_set_iot, tto_clr, tpc;
    logic rx_set, tx_set, tx_busy;
    logic unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ack_q   <= 2'b00;
            rx_ack_q   <= 2'b00;
            tx_empty_q <= 2'b11;
            rx_empty_q <= 2'b11;
        end else begin
            tx_ack_q   <= {tx_ack_q[0], tx_ack};
            rx_ack_q   <= {rx_ack_q[0], rx_ack};
            tx_empty_q <= {tx_empty_q[0], tx_empty};
            rx_empty_q <= {rx_empty_q[0], rx_empty};
        end
    end

    assign tx_ack_s   = tx_ack_q[1];
    assign rx_ack_s   = rx_ack_q[1];
    assign tx_empty_s = tx_empty_q[1];
    assign rx_empty_s = rx_empty_q[1];

    assign kbd_hit = iot && (io_dev == KBD_DEV);
    assign tto_hit = iot && (io_dev == TTO_DEV);

    assign kbd_clr = kbd_hit &&
                     (io_op == 3'd0 || io_op == 3'd2 || io_op == 3'd6);
    assign tto_set_iot = tto_hit && (io_op == 3'd0);
    assign tto_clr = tto_hit && (io_op == 3'd2 || io_op == 3'd6);
    assign tpc     = tto_hit && (io_op == 3'd4 || io_op == 3'd6);

    assign rx_set  = (rx_state == R_REL) && !rx_ack_s;
    assign tx_set  = (tx_state == T_DRAIN) && tx_empty_s;
    assign tx_busy = (tx_state != T_IDLE) || tx_pend;

    assign tx_data = tto_buf;
    assign unused  = ^io_data_in[11:8];

    // Response is registered: valid exactly one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_done     <= 1'b0;
            io_skip     <= 1'b0;
            io_clear_ac <= 1'b0;
            io_data_out <= 12'o0;
        end else begin
            io_done     <= kbd_hit || tto_hit;
            io_skip     <= (kbd_hit && io_op == 3'd1 && kbd_flag) ||
                           (tto_hit && io_op == 3'd1 && tto_flag);
            io_clear_ac <= kbd_hit && (io_op == 3'd2 || io_op == 3'd6);
            io_data_out <= (kbd_hit && (io_op == 3'd4 || io_op == 3'd6))
                           ? {4'b0000, kbd_buf} : 12'o0;
        end
    end

    // FSM sets take priority over IOT clears in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_flag <= 1'b0;
            tto_flag <= 1'b0;
        end else begin
            if (rx_set)
                kbd_flag <= 1'b1;
            else if (kbd_clr)
                kbd_flag <= 1'b0;
            if (tx_set || tto_set_iot)
                tto_flag <= 1'b1;
            else if (tto_clr)
                tto_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= R_IDLE;
            rx_req   <= 1'b0;
            kbd_buf  <= 8'h00;
        end else begin
            case (rx_state)
                R_IDLE: if (!kbd_flag && !rx_empty_s) begin
                    rx_req   <= 1'b1;
                    rx_state <= R_REQ;
                end
                R_REQ: if (rx_ack_s) begin
                    rx_req   <= 1'b0;
                    rx_state <= R_REL;
                end
                R_REL: if (!rx_ack_s) begin
                    kbd_buf  <= rx_data;
                    rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // A character offered while a transfer is outstanding is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= T_IDLE;
            tx_req   <= 1'b0;
            tx_pend  <= 1'b0;
            tto_buf  <= 8'h00;
        end else begin
            if (tpc && !tx_busy) begin
                tto_buf <= io_data_in[7:0];
                tx_pend <= 1'b1;
            end
            case (tx_state)
                T_IDLE: if (tx_pend && tx_empty_s) begin
                    tx_req   <= 1'b1;
                    tx_pend  <= 1'b0;
                    tx_state <= T_REQ;
                end
                T_REQ: if (tx_ack_s) begin
                    tx_req   <= 1'b0;
                    tx_state <= T_REL;
                end
                T_REL: if (!tx_ack_s)
                    tx_state <= T_DRAIN;
                T_DRAIN: if (tx_empty_s)
                    tx_state <= T_IDLE;
                default: tx_state <= T_IDLE;
            endcase
        end
    end

`ifdef TTY_INT_EN
    logic int_enable;

    always_ff @(posedge clk) begin
        if (reset)
            int_enable <= 1'b1;
        else if (kbd_hit && io_op == 3'd5)
            int_enable <= io_data_in[0];
    end

    assign io_irq = int_enable && (kbd_flag || tto_flag);
`else
    assign io_irq = 1'b0;
`endif

endmodule

// File: tb/tb_tty_kl8e.sv
// Randomized bench for tty_kl8e against a flag/buffer level model of the teletype.
module tb_tty_kl8e;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iot = 1'b0;
    logic [5:0]  io_dev = 6'o0;
    logic [2:0]  io_op = 3'd0;
    logic [11:0] io_data_in = 12'o0;
    logic        io_done, io_clear_ac, io_skip, io_irq;
    logic [11:0] io_data_out;
    logic        tx_req, rx_req;
    logic        tx_ack = 1'b0;
    logic        tx_empty = 1'b1;
    logic [7:0]  tx_data;
    logic        rx_ack = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'h00;

    int   n_vec = 0;
    int   n_err = 0;
    int   pulses = 0;
    logic req_d = 1'b0;
    logic [7:0] cap = 8'h00;

    // reference model state
    bit       m_kf, m_tf, m_ie;
    bit [7:0] m_kbuf;

    tty_kl8e dut (
        .clk(clk), .reset(reset), .iot(iot), .io_dev(io_dev),
        .io_op(io_op), .io_data_in(io_data_in), .io_done(io_done),
        .io_data_out(io_data_out), .io_clear_ac(io_clear_ac),
        .io_skip(io_skip), .io_irq(io_irq), .tx_req(tx_req),
        .tx_ack(tx_ack), .tx_data(tx_data), .tx_empty(tx_empty),
        .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data),
        .rx_empty(rx_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_d <= tx_req;
        if (tx_req && !req_d)
            pulses <= pulses + 1;
    end

    // UART transmit side: ack, then hold tx_empty low for a drain period
    initial begin
        forever begin
            @(negedge clk);
            if (tx_req) begin
                cap = tx_data;
                repeat (2) @(negedge clk);
                tx_ack = 1'b1;
                tx_empty = 1'b0;
                for (int n = 0; n < 100 && tx_req; n++)
                    @(negedge clk);
                tx_ack = 1'b0;
                repeat (30) @(negedge clk);
                tx_empty = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit exp_irq();
`ifdef TTY_INT_EN
        return m_ie && (m_kf || m_tf);
`else
        return 1'b0;
`endif
    endfunction

    task automatic iot_chk(input logic [5:0] dev, input logic [2:0] op,
                           input logic [11:0] ac);
        bit e_done, e_skip, e_clr;
        bit [11:0] e_data;
        e_done = 0; e_skip = 0; e_clr = 0; e_data = 12'o0;
        if (dev == 6'o03) begin
            e_done = 1;
            case (op)
                3'd0: m_kf = 0;
                3'd1: e_skip = m_kf;
                3'd2: begin e_clr = 1; m_kf = 0; end
                3'd4: e_data = {4'b0, m_kbuf};
                3'd5: m_ie = ac[0];
                3'd6: begin e_clr = 1; e_data = {4'b0, m_kbuf}; m_kf = 0; end
                default: ;
            endcase
        end else if (dev == 6'o04) begin
            e_done = 1;
            case (op)
                3'd0: m_tf = 1;
                3'd1: e_skip = m_tf;
                3'd2: m_tf = 0;
                3'd6: m_tf = 0;
                default: ;
            endcase
        end
        iot = 1'b1; io_dev = dev; io_op = op; io_data_in = ac;
        tick();
        iot = 1'b0; io_dev = 6'o0; io_op = 3'd0; io_data_in = 12'o0;
        check($sformatf("resp d%0o op%0d", dev, op),
              {io_done, io_skip, io_clear_ac, io_data_out},
              {e_done, e_skip, e_clr, e_data});
        tick();
        check("resp_idle", {io_done, io_skip, io_clear_ac, io_data_out}, 0);
    endtask

    task automatic rx_send(input logic [7:0] ch, input bit same_kcf);
        int n;
        rx_data = 8'($urandom);
        rx_empty = 1'b0;
        n = 0;
        while (!rx_req && n < 50) begin tick(); n++; end
        check("rx_req_up", rx_req, 1);
        repeat (2) tick();
        rx_ack = 1'b1;
        tick();
        rx_data = ch;
        n = 0;
        while (rx_req && n < 50) begin tick(); n++; end
        check("rx_req_down", rx_req, 0);
        rx_ack = 1'b0;
        rx_empty = 1'b1;
        if (same_kcf) begin
            repeat (2) tick();
            iot_chk(6'o03, 3'd0, 12'($urandom));
        end else begin
            repeat (4) tick();
        end
        m_kf = 1;
        m_kbuf = ch;
    endtask

    task automatic tx_send(input bit tls, input logic [11:0] ac,
                           input bit extra_tpc);
        int p0, n;
        p0 = pulses;
        iot_chk(6'o04, tls ? 3'd6 : 3'd4, ac);
        n = 0;
        while (!tx_ack && n < 50) begin tick(); n++; end
        check("tx_hold", {tx_req, tx_data}, {1'b1, ac[7:0]});
        n = 0;
        while (tx_ack && n < 50) begin tick(); n++; end
        check("tx_ack_rel", tx_ack, 0);
        repeat (5) tick();
        iot_chk(6'o04, 3'd1, 12'($urandom));
        if (extra_tpc) begin
            iot_chk(6'o04, 3'd4, 12'($urandom));
            check("tx_keep", tx_data, {24'h0, ac[7:0]});
        end
        n = 0;
        while (!tx_empty && n < 60) begin tick(); n++; end
        repeat (4) tick();
        m_tf = 1;
        iot_chk(6'o04, 3'd1, 12'($urandom));
        repeat (10) tick();
        check("tx_pulses", pulses - p0, 1);
        check("tx_char", cap, {24'h0, ac[7:0]});
        n = 0;
        while ((!tx_empty || tx_ack) && n < 100) begin tick(); n++; end
    endtask

    task automatic model_reset();
        m_kf = 0; m_tf = 0; m_ie = 1; m_kbuf = 8'h00;
    endtask

    initial begin
        logic [5:0] dev;
        logic [2:0] op;
        int sel;
        model_reset();
        repeat (4) tick();
        check("reset_out",
              {tx_req, rx_req, tx_data, io_done, io_skip, io_clear_ac,
               io_data_out, io_irq}, 0);
        reset = 1'b0;
        tick();
        iot_chk(6'o03, 3'd1, 12'o0);
        iot_chk(6'o04, 3'd1, 12'o0);
        check("idle_reqs", {tx_req, rx_req}, 0);

        rx_send(8'o101, 1'b0);
        iot_chk(6'o03, 3'd1, 12'o0);
        iot_chk(6'o03, 3'd6, 12'o5252);
        iot_chk(6'o03, 3'd1, 12'o0);

        tx_send(1'b1, 12'o7215, 1'b1);
        check("irq_tx", io_irq, exp_irq());

        rx_send(8'($urandom), 1'b1);
        iot_chk(6'o03, 3'd1, 12'o0);
        iot_chk(6'o03, 3'd5, 12'o0);
        check("irq_kie0", io_irq, exp_irq());
        iot_chk(6'o03, 3'd5, 12'o1);
        check("irq_kie1", io_irq, exp_irq());

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                if (m_kf) iot_chk(6'o03, 3'd6, 12'($urandom));
                rx_send(8'($urandom), 1'($urandom));
            end else if (sel < 5) begin
                iot_chk(6'o03, 3'($urandom), 12'($urandom));
            end else if (sel < 8) begin
                case ($urandom_range(0, 5))
                    0: op = 3'd0;
                    1: op = 3'd1;
                    2: op = 3'd2;
                    3: op = 3'd3;
                    4: op = 3'd5;
                    default: op = 3'd7;
                endcase
                iot_chk(6'o04, op, 12'($urandom));
            end else if (sel == 8) begin
                tx_send(1'($urandom), 12'($urandom), 1'($urandom));
            end else begin
                dev = 6'($urandom_range(5, 63));
                iot_chk(dev, 3'($urandom), 12'($urandom));
            end
            check("irq", io_irq, exp_irq());
        end

        rx_empty = 1'b0;
        if (m_kf) iot_chk(6'o03, 3'd2, 12'o0);
        for (int n = 0; n < 50 && !rx_req; n++) tick();
        check("rx_req_pre_rst", rx_req, 1);
        reset = 1'b1;
        rx_empty = 1'b1;
        tick();
        check("mid_reset",
              {tx_req, rx_req, tx_data, io_done, io_skip, io_clear_ac,
               io_data_out, io_irq}, 0);
        reset = 1'b0;
        model_reset();
        tick();
        iot_chk(6'o03, 3'd4, 12'o0);
        iot_chk(6'o03, 3'd1, 12'o0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
